// File: rtl/pe_pkg.sv
// Shared types for the pe operand feeder: default widths, feeder FSM state
// encoding and the per-lane beat record that travels down the skew lines.
package pe_pkg;

    localparam int unsigned D_W_DEFAULT     = 8;
    localparam int unsigned D_W_ACC_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,  // accumulator clean, nothing open
        ACTIVE   = 2'd1,  // dot product open
        BOUNDARY = 2'd2   // s_last accepted on the previous edge
    } feeder_state_t;

    // One lane's worth of PE input. occ marks a data or flush beat; bubbles
    // leave it clear so they never keep busy asserted.
    typedef struct packed {
        logic [D_W_DEFAULT-1:0] a;
        logic [D_W_DEFAULT-1:0] b;
        logic                   init;
        logic                   occ;
    } beat_t;

    localparam beat_t BEAT_ZERO = '0;

    function automatic beat_t make_beat(input logic [D_W_DEFAULT-1:0] a,
                                        input logic [D_W_DEFAULT-1:0] b,
                                        input logic                   init,
                                        input logic                   occ);
        beat_t r;
        r.a    = a;
        r.b    = b;
        r.init = init;
        r.occ  = occ;
        return r;
    endfunction

endpackage

// File: rtl/pe_operand_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register of beat records used to
// stagger one lane of the feeder output. occ_o reports whether any stage
// currently holds a data or flush beat.
module skew_delay_line
    import pe_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  beat_t beat_i,
    output beat_t beat_o,
    output logic  occ_o
);

    beat_t stage_q [DEPTH];

    // Shift one stage per cycle; reset wipes every stage at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= BEAT_ZERO;
            end
        end else begin
            stage_q[0] <= beat_i;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign beat_o = stage_q[DEPTH-1];

    // Occupancy is the OR of every stage's occ flag.
    always_comb begin
        occ_o = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_o = occ_o | stage_q[k].occ;
        end
    end

endmodule

// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: turns a valid/ready stream of dot-product operand beats
// into the in_a/in_b/init sequence a row of pe elements expects. Zero bubbles
// fill idle cycles and a trailing flush init drains the last sum.
// Optional feature macro: PE_FEEDER_SKEW_EN delays lane i by i cycles.
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready.
// s_ready is simply !rst, so the feeder never back-pressures; s_a/s_b/s_last
// are only looked at on transfer edges.
module pe_operand_feeder
    import pe_pkg::*;
#(
    parameter int unsigned D_W = D_W_DEFAULT,
    parameter int unsigned N   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N*D_W-1:0]   s_a,
    input  logic [N*D_W-1:0]   s_b,
    input  logic               s_last,
    output logic [N*D_W-1:0]   out_a,
    output logic [N*D_W-1:0]   out_b,
    output logic [N-1:0]       out_init,
    output logic               busy,
    output feeder_state_t      dbg_state
);

    feeder_state_t state_q;
    beat_t         emit_q    [N];
    beat_t         lane_beat [N];
    logic          accept;
    logic          mark_init;

    assign s_ready   = ~rst;
    assign accept    = s_valid & s_ready;
    assign dbg_state = state_q;

    // Every beat leaving BOUNDARY carries init, whether data or flush.
    always_comb begin
        mark_init = (state_q == BOUNDARY);
    end

    // Feeder FSM plus the registered lane-0 emission for every lane's operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < int'(N); i++) begin
                emit_q[i] <= BEAT_ZERO;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                emit_q[i] <= make_beat(accept ? s_a[i*D_W +: D_W] : '0,
                                       accept ? s_b[i*D_W +: D_W] : '0,
                                       mark_init,
                                       accept | mark_init);
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= s_last ? BOUNDARY : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept && s_last) begin
                        state_q <= BOUNDARY;
                    end
                end
                BOUNDARY: begin
                    if (accept) begin
                        state_q <= s_last ? BOUNDARY : ACTIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PE_FEEDER_SKEW_EN
    logic [N-1:0] lane_occ;

    assign lane_beat[0] = emit_q[0];
    assign lane_occ[0]  = emit_q[0].occ;

    // Lane i sees its operand i cycles after lane 0 to form a wavefront.
    for (genvar i = 1; i < int'(N); i++) begin : g_skew
        skew_delay_line #(
            .DEPTH (i)
        ) u_skew (
            .clk    (clk),
            .rst    (rst),
            .beat_i (emit_q[i]),
            .beat_o (lane_beat[i]),
            .occ_o  (lane_occ[i])
        );
    end

    // Busy while a dot product is open or any beat is still in flight.
    always_comb begin
        busy = (state_q != IDLE) | (|lane_occ);
    end
`else
    logic [N-1:0] unused_occ;

    // All lanes come straight off the emission register.
    for (genvar i = 0; i < int'(N); i++) begin : g_flat
        assign lane_beat[i]  = emit_q[i];
        assign unused_occ[i] = emit_q[i].occ;
    end

    // Without skew stages, busy follows the FSM alone.
    always_comb begin
        busy = (state_q != IDLE);
    end
`endif

    // Pack per-lane beats onto the flat PE-facing buses.
    always_comb begin
        out_a    = '0;
        out_b    = '0;
        out_init = '0;
        for (int i = 0; i < int'(N); i++) begin
            out_a[i*D_W +: D_W] = lane_beat[i].a;
            out_b[i*D_W +: D_W] = lane_beat[i].b;
            out_init[i]         = lane_beat[i].init;
        end
    end

endmodule
